matrix_op_scheduler: RTL and testbench

- Sequences all access to the matrix storage block so only one transaction runs at a time.
- Round-robin arbitrates three requesters: matrix entry (input), matrix display, and computation.
- Generates the storage control strobes (start_input, start_disp, load_operands, op_done, read_en) and the ALU start/result-index handshake, with an inactivity watchdog.

---
 rtl/matrix_op_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_matrix_op_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_scheduler.sv
// Serialises access to matrix storage among input, display and compute requesters
// and sequences storage strobes, the ALU handshake and an inactivity watchdog.
module matrix_op_scheduler #(
  parameter int SEARCH_CYC = 13,
  parameter int TIMEOUT    = 50000,
  parameter int TO_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_input,
  input  logic       req_disp,
  input  logic       req_calc,
  input  logic [2:0] in_m,
  input  logic [2:0] in_n,
  input  logic [3:0] disp_id,
  input  logic [4:0] disp_len,
  input  logic [3:0] op_a_id,
  input  logic [3:0] op_b_id,
  input  logic [2:0] res_m,
  input  logic [2:0] res_n,
  input  logic       wr_strobe,
  input  logic       disp_ready,
  input  logic       alu_done,
  input  logic       storage_error,
  output logic       gnt_input,
  output logic       gnt_disp,
  output logic       gnt_calc,
  output logic       start_input,
  output logic       start_disp,
  output logic       load_operands,
  output logic       op_done,
  output logic       write_en,
  output logic       read_en,
  output logic [2:0] dim_m,
  output logic [2:0] dim_n,
  output logic [3:0] matrix_id_in,
  output logic [3:0] operand_a_id,
  output logic [3:0] operand_b_id,
  output logic       alu_start,
  output logic [4:0] res_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam int SC_W = $clog2(SEARCH_CYC + 1);
  localparam logic [SC_W-1:0] SRCH_LAST = SC_W'(SEARCH_CYC - 1);
  localparam logic [TO_W-1:0] WD_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_DATA, RD_DATA, LOAD, CALC, STORE
  } state_t;

  state_t          state;
  logic [1:0]      last;
  logic            bad_pend;
  logic [SC_W-1:0] cyc;
  logic [4:0]      elem;
  logic [4:0]      len_q;
  logic [2:0]      rm_q, rn_q;
  logic [TO_W-1:0] wd;

  logic [4:0] wr_total, res_total;
  logic [3:0] reqv;
  logic [1:0] c0, c1, pick;
  logic       any_req, input_ok, disp_ok, progress, abort;

  assign wr_total  = {2'b00, dim_m} * {2'b00, dim_n};
  assign res_total = {2'b00, rm_q} * {2'b00, rn_q};
  assign input_ok  = (in_m != 3'd0) && (in_m <= 3'd5) && (in_n != 3'd0) && (in_n <= 3'd5);
  assign disp_ok   = (disp_len != 5'd0) && (disp_id <= 4'd9);

  assign write_en  = (state == WR_DATA) && wr_strobe && !storage_error;
  assign read_en   = (state == RD_DATA) && !start_disp && disp_ready && !storage_error;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  assign reqv    = {1'b0, req_calc, req_disp, req_input};
  assign any_req = |reqv;

  // Rotating priority: the two requesters after the last grant come first.
  always_comb begin
    c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
    if (reqv[c0])      pick = c0;
    else if (reqv[c1]) pick = c1;
    else               pick = last;
  end

  always_comb begin
    progress = 1'b0;
    case (state)
      WR_SETUP: progress = (cyc == SRCH_LAST);
      WR_DATA:  progress = write_en;
      RD_DATA:  progress = read_en;
      LOAD:     progress = (cyc == SC_W'(1));
      CALC:     progress = alu_done;
      STORE:    progress = !op_done || (cyc == SRCH_LAST);
      default:  progress = 1'b0;
    endcase
    abort = 1'b0;
    if (state != IDLE) begin
      if (storage_error && (state == WR_DATA || state == RD_DATA || state == STORE))
        abort = 1'b1;
      if (!progress && (wd == WD_LAST))
        abort = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last          <= 2'd2;
      bad_pend      <= 1'b0;
      cyc           <= '0;
      elem          <= '0;
      len_q         <= '0;
      rm_q          <= '0;
      rn_q          <= '0;
      wd            <= '0;
      gnt_input     <= 1'b0;
      gnt_disp      <= 1'b0;
      gnt_calc      <= 1'b0;
      start_input   <= 1'b0;
      start_disp    <= 1'b0;
      load_operands <= 1'b0;
      op_done       <= 1'b0;
      dim_m         <= '0;
      dim_n         <= '0;
      matrix_id_in  <= '0;
      operand_a_id  <= '0;
      operand_b_id  <= '0;
      alu_start     <= 1'b0;
      res_idx       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      gnt_input <= 1'b0;
      gnt_disp  <= 1'b0;
      gnt_calc  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        err           <= 1'b1;
        start_input   <= 1'b0;
        start_disp    <= 1'b0;
        load_operands <= 1'b0;
        op_done       <= 1'b0;
        alu_start     <= 1'b0;
        res_idx       <= '0;
        cyc           <= '0;
        elem          <= '0;
        wd            <= '0;
      end else begin
        if (state == IDLE || progress) wd <= '0;
        else                           wd <= wd + 1'b1;
        case (state)
          IDLE: begin
            // A rejected grant holds off arbitration for the grant cycle, then reports err.
            bad_pend <= 1'b0;
            if (bad_pend) begin
              err <= 1'b1;
            end else if (any_req) begin
              last <= pick;
              cyc  <= '0;
              elem <= '0;
              case (pick)
                2'd0: begin
                  gnt_input <= 1'b1;
                  dim_m     <= in_m;
                  dim_n     <= in_n;
                  if (input_ok) begin
                    state       <= WR_SETUP;
                    start_input <= 1'b1;
                  end else begin
                    bad_pend <= 1'b1;
                  end
                end
                2'd1: begin
                  gnt_disp     <= 1'b1;
                  matrix_id_in <= disp_id;
                  len_q        <= disp_len;
                  if (disp_ok) begin
                    state      <= RD_DATA;
                    start_disp <= 1'b1;
                  end else begin
                    bad_pend <= 1'b1;
                  end
                end
                default: begin
                  gnt_calc      <= 1'b1;
                  operand_a_id  <= op_a_id;
                  operand_b_id  <= op_b_id;
                  state         <= LOAD;
                  load_operands <= 1'b1;
                end
              endcase
            end
          end
          WR_SETUP: begin
            if (cyc == SRCH_LAST) begin
              start_input <= 1'b0;
              state       <= WR_DATA;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          WR_DATA: begin
            if (write_en) begin
              if (elem == wr_total - 5'd1) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                elem <= elem + 5'd1;
              end
            end
          end
          RD_DATA: begin
            start_disp <= 1'b0;
            if (read_en) begin
              if (elem == len_q - 5'd1) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                elem <= elem + 5'd1;
              end
            end
          end
          LOAD: begin
            load_operands <= 1'b0;
            if (cyc == SC_W'(1)) begin
              alu_start <= 1'b1;
              state     <= CALC;
              cyc       <= '0;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          CALC: begin
            alu_start <= 1'b0;
            if (alu_done) begin
              rm_q    <= res_m;
              rn_q    <= res_n;
              state   <= STORE;
              op_done <= 1'b1;
              cyc     <= '0;
            end
          end
          STORE: begin
            if (op_done) begin
              if (cyc == SRCH_LAST) begin
                op_done <= 1'b0;
                res_idx <= '0;
              end else begin
                cyc <= cyc + 1'b1;
              end
            end else if (res_total == 5'd0 || res_idx == res_total - 5'd1) begin
              state   <= IDLE;
              done    <= 1'b1;
              res_idx <= '0;
            end else begin
              res_idx <= res_idx + 5'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Self-checking bench for matrix_op_scheduler: vector table, arbitration model,
// randomized transactions and hand-written abort/reset sequences.
module tb_matrix_op_scheduler;

  localparam int SC = 13;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst;
  logic req_input, req_disp, req_calc;
  logic [2:0] in_m, in_n, res_m, res_n;
  logic [3:0] disp_id, op_a_id, op_b_id;
  logic [4:0] disp_len;
  logic wr_strobe, disp_ready, alu_done, storage_error;
  logic gnt_input, gnt_disp, gnt_calc;
  logic start_input, start_disp, load_operands, op_done, write_en, read_en;
  logic [2:0] dim_m, dim_n;
  logic [3:0] matrix_id_in, operand_a_id, operand_b_id;
  logic alu_start;
  logic [4:0] res_idx;
  logic busy, done, err;
  logic [2:0] state_dbg;
  logic [38:0] outs;

  always #5 clk = ~clk;

  matrix_op_scheduler #(.SEARCH_CYC(SC), .TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_input(req_input), .req_disp(req_disp), .req_calc(req_calc),
    .in_m(in_m), .in_n(in_n), .disp_id(disp_id), .disp_len(disp_len),
    .op_a_id(op_a_id), .op_b_id(op_b_id), .res_m(res_m), .res_n(res_n),
    .wr_strobe(wr_strobe), .disp_ready(disp_ready), .alu_done(alu_done),
    .storage_error(storage_error),
    .gnt_input(gnt_input), .gnt_disp(gnt_disp), .gnt_calc(gnt_calc),
    .start_input(start_input), .start_disp(start_disp),
    .load_operands(load_operands), .op_done(op_done),
    .write_en(write_en), .read_en(read_en),
    .dim_m(dim_m), .dim_n(dim_n), .matrix_id_in(matrix_id_in),
    .operand_a_id(operand_a_id), .operand_b_id(operand_b_id),
    .alu_start(alu_start), .res_idx(res_idx),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  assign outs = {gnt_input, gnt_disp, gnt_calc, start_input, start_disp, load_operands,
                 op_done, write_en, read_en, dim_m, dim_n, matrix_id_in, operand_a_id,
                 operand_b_id, alu_start, res_idx, busy, done, err, state_dbg};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Transaction observations
  int r_gnt, r_gnt_cyc, r_start, r_sdisp, r_wr, r_rd, r_rdbad, r_ld, r_as, r_opd;
  int r_idx, r_idxbad, r_done, r_err, r_end_cyc, r_both, r_busy_end, r_stall, r_serr_cyc;
  // Stimulus controls
  int strobe_limit = 1000;
  int serr_after = -1;
  int alu_delay = 20;
  int ready_mode = 0;

  task automatic idle_inputs();
    req_input = 0; req_disp = 0; req_calc = 0;
    wr_strobe = 0; disp_ready = 0; alu_done = 0; storage_error = 0;
  endtask

  task automatic txn(input int kind, input logic [2:0] m, input logic [2:0] n,
                     input logic [3:0] id, input logic [4:0] len,
                     input logic [2:0] rm, input logic [2:0] rn);
    bit start_seen, as_seen, opd_seen, serr_done;
    int as_cyc;
    start_seen = 0; as_seen = 0; opd_seen = 0; serr_done = 0; as_cyc = 0;
    r_gnt = 0; r_gnt_cyc = 0; r_start = 0; r_sdisp = 0; r_wr = 0; r_rd = 0; r_rdbad = 0;
    r_ld = 0; r_as = 0; r_opd = 0; r_idx = 0; r_idxbad = 0; r_done = 0; r_err = 0;
    r_end_cyc = 0; r_both = 0; r_busy_end = 1; r_stall = 0; r_serr_cyc = -100;
    in_m = m; in_n = n; disp_id = id; disp_len = len; res_m = rm; res_n = rn;
    op_a_id = id; op_b_id = ~id;
    req_input = (kind == 0); req_disp = (kind == 1); req_calc = (kind == 2);
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(posedge clk); #1;
      storage_error = (serr_after >= 0) && !serr_done && (r_wr == serr_after) &&
                      start_seen && !start_input;
      if (storage_error) begin serr_done = 1; r_serr_cyc = cyc; end
      wr_strobe = start_seen && !start_input && !storage_error && (r_wr < strobe_limit) &&
                  ($urandom_range(0, 1) == 1);
      disp_ready = (ready_mode != 0) ? ((cyc % 2) == 1) : ($urandom_range(0, 1) == 1);
      alu_done = as_seen && ((cyc - as_cyc) == alu_delay);
      #1;
      if ((kind == 0 && gnt_input) || (kind == 1 && gnt_disp) || (kind == 2 && gnt_calc)) begin
        r_gnt++; r_gnt_cyc = cyc;
        req_input = 0; req_disp = 0; req_calc = 0;
      end
      if (start_input) begin r_start++; start_seen = 1; end
      if (start_disp) r_sdisp++;
      if (write_en) begin r_wr++; r_stall = 0; end
      else if (start_seen && !start_input && busy) r_stall++;
      if (read_en) begin r_rd++; if (!disp_ready || start_disp) r_rdbad++; end
      if (load_operands) r_ld++;
      if (alu_start) begin r_as++; as_seen = 1; as_cyc = cyc; end
      if (op_done) begin r_opd++; opd_seen = 1; end
      else if (opd_seen && busy) begin
        if (int'(res_idx) != r_idx) r_idxbad++;
        r_idx++;
      end
      if (done && err) r_both++;
      if (done) r_done++;
      if (err) r_err++;
      if (done || err) begin r_end_cyc = cyc; r_busy_end = busy; break; end
    end
    idle_inputs();
  endtask

  task automatic check_txn(input string name, input int kind, input int ok, input int cnt);
    check({name, "_gnt"}, r_gnt, 1);
    check({name, "_done"}, r_done, ok);
    check({name, "_err"}, r_err, 1 - ok);
    check({name, "_done_err_both"}, r_both, 0);
    check({name, "_busy_end"}, r_busy_end, 0);
    if (kind == 0) begin
      check({name, "_start_input_cyc"}, r_start, ok != 0 ? SC : 0);
      check({name, "_write_en"}, r_wr, cnt);
    end else if (kind == 1) begin
      check({name, "_start_disp"}, r_sdisp, ok);
      check({name, "_read_en"}, r_rd, cnt);
      check({name, "_read_en_bad"}, r_rdbad, 0);
    end else begin
      check({name, "_load"}, r_ld, 1);
      check({name, "_alu_start"}, r_as, 1);
      check({name, "_op_done_cyc"}, r_opd, SC);
      check({name, "_res_idx_cnt"}, r_idx, cnt);
      check({name, "_res_idx_seq"}, r_idxbad, 0);
    end
    if (ok == 0) check({name, "_err_latency"}, r_end_cyc - r_gnt_cyc, 1);
  endtask

  // Arbitration model: rotating priority after the last granted requester.
  int tb_last = 2;

  task automatic rr_run(input bit ri, input bit rd, input bit rc);
    int exp_q[$];
    bit pend[3];
    int got_n, dones, overlap, as_cyc;
    bit prev_busy, as_seen;
    pend[0] = ri; pend[1] = rd; pend[2] = rc;
    for (int s = 0; s < 3; s++)
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (tb_last + k) % 3;
        if (pend[c]) begin exp_q.push_back(c); pend[c] = 0; tb_last = c; break; end
      end
    in_m = 3'd2; in_n = 3'd2; disp_id = 4'd4; disp_len = 5'd4; res_m = 3'd2; res_n = 3'd2;
    op_a_id = 4'd1; op_b_id = 4'd2;
    req_input = ri; req_disp = rd; req_calc = rc;
    got_n = 0; dones = 0; overlap = 0; prev_busy = busy; as_seen = 0; as_cyc = 0;
    for (int cyc = 0; cyc < 2000 && dones < exp_q.size(); cyc++) begin
      @(posedge clk); #1;
      wr_strobe = 1; disp_ready = 1;
      alu_done = as_seen && (cyc - as_cyc == 3);
      #1;
      if (gnt_input || gnt_disp || gnt_calc) begin
        int who;
        who = gnt_input ? 0 : (gnt_disp ? 1 : 2);
        if (prev_busy) overlap++;
        if (got_n < exp_q.size()) check("rr_order", who, exp_q[got_n]);
        got_n++;
        if (who == 0) req_input = 0;
        if (who == 1) req_disp = 0;
        if (who == 2) req_calc = 0;
      end
      if (alu_start) begin as_seen = 1; as_cyc = cyc; end
      if (done) dones++;
      prev_busy = busy;
    end
    check("rr_grant_count", got_n, exp_q.size());
    check("rr_done_count", dones, exp_q.size());
    check("rr_grant_while_busy", overlap, 0);
    idle_inputs();
  endtask

  typedef struct {
    int kind;
    logic [2:0] m, n;
    logic [3:0] id;
    logic [4:0] len;
    logic [2:0] rm, rn;
    int exp_ok;
    int exp_cnt;
  } vec_t;

  function automatic vec_t mk(int kind, int m, int n, int id, int len, int rm, int rn,
                              int ok, int cnt);
    vec_t v;
    v.kind = kind; v.m = 3'(m); v.n = 3'(n); v.id = 4'(id); v.len = 5'(len);
    v.rm = 3'(rm); v.rn = 3'(rn); v.exp_ok = ok; v.exp_cnt = cnt;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(0, 2, 3, 0, 0, 0, 0, 1, 6);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 1);
    tbl[2]  = mk(0, 5, 5, 0, 0, 0, 0, 1, 25);
    tbl[3]  = mk(0, 6, 2, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 3, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 3, 7, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 4, 9, 0, 0, 1, 9);
    tbl[7]  = mk(1, 0, 0, 9, 1, 0, 0, 1, 1);
    tbl[8]  = mk(1, 0, 0, 10, 3, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[10] = mk(2, 0, 0, 3, 0, 3, 3, 1, 9);
    tbl[11] = mk(2, 0, 0, 5, 0, 1, 2, 1, 2);

    idle_inputs();
    in_m = 0; in_n = 0; disp_id = 0; disp_len = 0; op_a_id = 0; op_b_id = 0;
    res_m = 0; res_n = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_nonzero_bits", $countones(outs), 0);
    rst = 0;
    @(posedge clk); #2;
    check("reset_release_outs", $countones(outs), 0);
    check("reset_state_dbg", int'(state_dbg), 0);

    // Arbitration: all three at once, then rotating pairs
    rr_run(1, 1, 1);
    rr_run(0, 1, 1);
    rr_run(1, 0, 1);
    rr_run(1, 1, 0);

    foreach (tbl[i]) begin
      txn(tbl[i].kind, tbl[i].m, tbl[i].n, tbl[i].id, tbl[i].len, tbl[i].rm, tbl[i].rn);
      check_txn($sformatf("vec%0d", i), tbl[i].kind, tbl[i].exp_ok, tbl[i].exp_cnt);
    end

    // Display with disp_ready alternating
    ready_mode = 1;
    txn(1, 0, 0, 4'd4, 5'd9, 0, 0);
    check_txn("disp_toggle", 1, 1, 9);
    ready_mode = 0;

    // Randomized transactions against the rule model
    for (int i = 0; i < 30; i++) begin
      int kind, ok, cnt;
      logic [2:0] m, n, rm, rn;
      logic [3:0] id;
      logic [4:0] len;
      kind = $urandom_range(0, 2);
      m = 3'($urandom_range(0, 7)); n = 3'($urandom_range(0, 7));
      id = 4'($urandom_range(0, 15)); len = 5'($urandom_range(0, 31));
      rm = 3'($urandom_range(1, 5)); rn = 3'($urandom_range(1, 5));
      if (kind == 0) begin
        ok = (m >= 1 && m <= 5 && n >= 1 && n <= 5) ? 1 : 0;
        cnt = ok != 0 ? int'(m) * int'(n) : 0;
      end else if (kind == 1) begin
        ok = (len != 0 && id <= 9) ? 1 : 0;
        cnt = ok != 0 ? int'(len) : 0;
      end else begin
        ok = 1;
        cnt = int'(rm) * int'(rn);
      end
      txn(kind, m, n, id, len, rm, rn);
      check_txn($sformatf("rand%0d", i), kind, ok, cnt);
    end

    // Watchdog: WR_DATA stalls after two elements
    strobe_limit = 2;
    txn(0, 3'd2, 3'd3, 0, 0, 0, 0);
    strobe_limit = 1000;
    check("wd_err", r_err, 1);
    check("wd_done", r_done, 0);
    check("wd_elements", r_wr, 2);
    check("wd_stall_cycles", r_stall, TO);
    check("wd_busy_end", r_busy_end, 0);

    // Storage error during WR_DATA after two elements
    serr_after = 2;
    txn(0, 3'd2, 3'd3, 0, 0, 0, 0);
    serr_after = -1;
    check("serr_err", r_err, 1);
    check("serr_done", r_done, 0);
    check("serr_elements", r_wr, 2);
    check("serr_latency", r_end_cyc - r_serr_cyc, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      wr_strobe = 1;
      #1;
      check("serr_write_en_stopped", int'(write_en), 0);
    end
    idle_inputs();

    // Reset in the middle of STORE
    begin
      int n_opd, as_cyc, ends;
      bit as_seen;
      n_opd = 0; as_cyc = 0; as_seen = 0; ends = 0;
      res_m = 3'd3; res_n = 3'd3; op_a_id = 4'd7; op_b_id = 4'd8;
      req_calc = 1;
      for (int c = 0; c < 200 && n_opd < 5; c++) begin
        @(posedge clk); #1;
        alu_done = as_seen && (c - as_cyc == 4);
        #1;
        if (gnt_calc) req_calc = 0;
        if (alu_start) begin as_seen = 1; as_cyc = c; end
        if (op_done) n_opd++;
      end
      check("store_reached", n_opd, 5);
      @(posedge clk); #1;
      alu_done = 0; rst = 1;
      @(posedge clk); #2;
      check("rst_store_outs", $countones(outs), 0);
      rst = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #2;
        if (done || err || busy) ends++;
      end
      check("rst_store_no_done_err", ends, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
